irq_timer_gen: RTL and testbench

IRQ_TIMER_GEN -- requirements
Module: irq_timer_gen

---
 rtl/irq_timer_gen.sv | 144 ++++++++++++++
 tb/tb_irq_timer_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_gen.sv
// Multi-channel periodic interrupt timer with a write-acknowledged config port and EOI handshake.
// Optional per-channel saturating overrun counters are built when IRQ_TIMER_OVERRUN_EN is defined.
module irq_timer_gen #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned IRQ_BASE   = 4,
    parameter int unsigned PERIOD_RST = 8191
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_valid,
    input  logic [3:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic                cfg_ready,
    input  logic [31:0]         eoi,
    output logic [31:0]         irq,
    output logic [8*NUM_CH-1:0] overrun_cnt
);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  per_q [NUM_CH];
    logic [CNT_W-1:0]  per_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] wr_per, wr_ctrl, dis_wr, fire;
    logic              cfg_ready_q, cfg_ready_d;
    logic              wr_en;
    logic              unused_in;

    // A write is taken only while no acknowledge is outstanding, giving one write per 2 cycles.
    assign wr_en       = cfg_valid & ~cfg_ready_q;
    assign cfg_ready_d = wr_en;
    assign cfg_ready   = cfg_ready_q;
    assign unused_in   = ^{cfg_wdata, eoi};

    always_comb begin
        wr_per  = '0;
        wr_ctrl = '0;
        dis_wr  = '0;
        fire    = '0;
        en_d    = en_q;
        pend_d  = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            per_d[i]   = per_q[i];
            wr_per[i]  = wr_en && (cfg_addr[3:1] == 3'(i)) && !cfg_addr[0];
            wr_ctrl[i] = wr_en && (cfg_addr[3:1] == 3'(i)) && cfg_addr[0];
            dis_wr[i]  = wr_ctrl[i] && !cfg_wdata[0];
            // Period loads and disables override a fire landing on the same edge.
            fire[i]    = en_q[i] && (cnt_q[i] == per_q[i]) && !wr_per[i] && !dis_wr[i];

            if (wr_per[i]) begin
                per_d[i] = cfg_wdata[CNT_W-1:0];
                cnt_d[i] = '0;
            end else if (!en_q[i] || dis_wr[i] || fire[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            if (wr_ctrl[i]) begin
                en_d[i] = cfg_wdata[0];
            end

            if (dis_wr[i]) begin
                pend_d[i] = 1'b0;
            end else if (fire[i]) begin
                pend_d[i] = 1'b1;
            end else if (eoi[IRQ_BASE+i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_ready_q <= 1'b0;
            en_q        <= '0;
            pend_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                per_q[i] <= CNT_W'(PERIOD_RST);
            end
        end else begin
            cfg_ready_q <= cfg_ready_d;
            en_q        <= en_d;
            pend_q      <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                per_q[i] <= per_d[i];
            end
        end
    end

    always_comb begin
        irq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            irq[IRQ_BASE+i] = pend_q[i];
        end
    end

`ifdef IRQ_TIMER_OVERRUN_EN
    logic [7:0]        ovr_q [NUM_CH];
    logic [7:0]        ovr_d [NUM_CH];
    logic [NUM_CH-1:0] ovr_evt;

    // An acknowledge coinciding with a fire absorbs it, so only unacknowledged refires count.
    always_comb begin
        ovr_evt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ovr_evt[i] = fire[i] && pend_q[i] && !eoi[IRQ_BASE+i];
            ovr_d[i]   = ovr_q[i];
            if (wr_ctrl[i] && cfg_wdata[1]) begin
                ovr_d[i] = 8'd0;
            end else if (ovr_evt[i] && (ovr_q[i] != 8'hFF)) begin
                ovr_d[i] = ovr_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ovr_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ovr_q[i] <= ovr_d[i];
            end
        end
    end

    always_comb begin
        overrun_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            overrun_cnt[8*i +: 8] = ovr_q[i];
        end
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_irq_timer_gen.sv
// Scoreboard bench for irq_timer_gen: directed writes queue expected cfg_ready and irq[4] rise
// cycles; a negedge monitor pops and compares, alongside direct state checks.
module tb_irq_timer_gen;

    localparam int OvrOn =
`ifdef IRQ_TIMER_OVERRUN_EN
        1;
`else
        0;
`endif

    logic        clk;
    logic        resetn;
    logic        cfg_valid;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_ready;
    logic [31:0] eoi;
    logic [31:0] irq;
    logic [15:0] overrun_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_edge = 0;
    int exp_rdy[$];
    int exp_irq[$];
    logic [31:0] irq_allow = 32'h10;
    logic        irq4_prev = 1'b0;

    irq_timer_gen #(
        .NUM_CH    (2),
        .CNT_W     (16),
        .IRQ_BASE  (4),
        .PERIOD_RST(8191)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_ready  (cfg_ready),
        .eoi        (eoi),
        .irq        (irq),
        .overrun_cnt(overrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops scoreboard entries whenever cfg_ready pulses or irq[4] rises.
    always @(negedge clk) begin
        int tmp;
        if (resetn) begin
            checks++;
            if ((irq & ~irq_allow) != 32'h0) begin
                errors++;
                $display("FAIL irq_mask: cycle %0d irq=%h allowed=%h", cyc, irq, irq_allow);
            end
            while (exp_rdy.size() > 0 && exp_rdy[0] < cyc) begin
                checks++;
                errors++;
                tmp = exp_rdy.pop_front();
                $display("FAIL cfg_ready_missed: expected pulse at cycle %0d, missing", tmp);
            end
            while (exp_irq.size() > 0 && exp_irq[0] < cyc) begin
                checks++;
                errors++;
                tmp = exp_irq.pop_front();
                $display("FAIL irq4_missed: expected rise at cycle %0d, missing", tmp);
            end
            if (cfg_ready) begin
                checks++;
                if (exp_rdy.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_ready_unexpected: pulse at cycle %0d, none expected", cyc);
                end else begin
                    tmp = exp_rdy.pop_front();
                    if (tmp != cyc) begin
                        errors++;
                        $display("FAIL cfg_ready_time: got cycle %0d expected %0d", cyc, tmp);
                    end
                end
            end
            if (irq[4] && !irq4_prev) begin
                checks++;
                if (exp_irq.size() == 0) begin
                    errors++;
                    $display("FAIL irq4_unexpected: rise at cycle %0d, none expected", cyc);
                end else begin
                    tmp = exp_irq.pop_front();
                    if (tmp != cyc) begin
                        errors++;
                        $display("FAIL irq4_time: got cycle %0d expected %0d", cyc, tmp);
                    end
                end
            end
        end
        irq4_prev = irq[4];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge with cfg_ready low; returns one negedge after the acknowledge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        wr_edge   = cyc + 1;
        exp_rdy.push_back(cyc + 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int w, c;
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = 4'h0;
        cfg_wdata = 32'h0;
        eoi       = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_irq", irq, 32'h0);
        chk("rst_ready", {31'h0, cfg_ready}, 32'h0);
        chk("rst_ovr", {16'h0, overrun_cnt}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // ch0 period 9: fires every 10 cycles after enable
        wr(4'h0, 32'd9);
        wr(4'h1, 32'd1);
        w = wr_edge;
        exp_irq.push_back(w + 10);
        exp_irq.push_back(w + 20);
        wait_cyc(w + 10);
        chk("first_fire", irq, 32'h10);
        eoi = 32'h10;
        wait_cyc(w + 11);
        eoi = 32'h0;
        chk("eoi_clears", irq, 32'h0);
        wait_cyc(w + 29);
        eoi = 32'h10;
        wait_cyc(w + 30);
        eoi = 32'h0;
        chk("fire_with_eoi_holds", irq, 32'h10);
        chk("fire_with_eoi_no_ovr", {24'h0, overrun_cnt[7:0]}, 32'h0);
        wait_cyc(w + 40);
        chk("ovr_ch0", {24'h0, overrun_cnt[7:0]}, OvrOn ? 32'd1 : 32'd0);
        eoi = 32'h10;
        wait_cyc(w + 41);
        eoi = 32'h0;
        chk("eoi_clears2", irq, 32'h0);

        // Period write lands on what would be the fire edge
        wait_cyc(w + 49);
        wr(4'h0, 32'd3);
        chk("period_wr_no_fire", irq, 32'h0);
        exp_irq.push_back(w + 54);
        wait_cyc(w + 55);
        wr(4'h1, 32'd0);
        chk("disable_clears", irq, 32'h0);
        chk("ovr_after_disable", {16'h0, overrun_cnt}, OvrOn ? 32'd1 : 32'd0);

        // cfg_valid held 6 cycles to a non-existent channel
        cfg_valid = 1'b1;
        cfg_addr  = 4'hE;
        cfg_wdata = 32'hFFFF_FFFF;
        c = cyc;
        exp_rdy.push_back(c + 1);
        exp_rdy.push_back(c + 3);
        exp_rdy.push_back(c + 5);
        repeat (6) @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        wr(4'hF, 32'h3);
        repeat (20) @(negedge clk);
        chk("bad_ch_irq", irq, 32'h0);
        chk("bad_ch_ovr", {16'h0, overrun_cnt}, OvrOn ? 32'd1 : 32'd0);

        // ch1 with P=0, never acknowledged
        irq_allow = 32'h30;
        wr(4'h2, 32'd0);
        wr(4'h3, 32'd1);
        w = wr_edge;
        wait_cyc(w + 1);
        chk("ch1_fire", irq, 32'h20);
        chk("ch1_ovr_0", {24'h0, overrun_cnt[15:8]}, 32'd0);
        wait_cyc(w + 2);
        chk("ch1_ovr_1", {24'h0, overrun_cnt[15:8]}, OvrOn ? 32'd1 : 32'd0);
        wait_cyc(w + 3);
        chk("ch1_ovr_2", {24'h0, overrun_cnt[15:8]}, OvrOn ? 32'd2 : 32'd0);
        wait_cyc(w + 255);
        chk("ch1_ovr_254", {24'h0, overrun_cnt[15:8]}, OvrOn ? 32'd254 : 32'd0);
        wait_cyc(w + 256);
        chk("ch1_ovr_255", {24'h0, overrun_cnt[15:8]}, OvrOn ? 32'd255 : 32'd0);
        wait_cyc(w + 300);
        chk("ch1_ovr_sat", {24'h0, overrun_cnt[15:8]}, OvrOn ? 32'd255 : 32'd0);
        wr(4'h3, 32'h3);
        chk("ch1_ovr_clear", {16'h0, overrun_cnt}, OvrOn ? 32'h0101 : 32'h0);
        wr(4'h3, 32'h0);
        chk("ch1_disable", irq, 32'h0);

        // Asynchronous reset mid-write with irq[4] pending
        wr(4'h1, 32'd1);
        w = wr_edge;
        exp_irq.push_back(w + 4);
        wait_cyc(w + 5);
        chk("pre_reset_irq", irq, 32'h10);
        cfg_valid = 1'b1;
        cfg_addr  = 4'h0;
        cfg_wdata = 32'd5;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_irq", irq, 32'h0);
        chk("async_rst_ready", {31'h0, cfg_ready}, 32'h0);
        chk("async_rst_ovr", {16'h0, overrun_cnt}, 32'h0);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        wr(4'h1, 32'd1);
        w = wr_edge;
        exp_irq.push_back(w + 8192);
        wait_cyc(w + 8193);
        chk("reset_period", irq, 32'h10);

        checks++;
        if (exp_rdy.size() != 0 || exp_irq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0",
                     exp_rdy.size(), exp_irq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
